// File: rtl/zed64_vram_pkg.sv
// Shared VRAM geometry and arbiter encodings for the zed64 video subsystem.
package zed64_vram_pkg;

  localparam int unsigned VRAM_AW = 13;
  localparam int unsigned VRAM_DW = 8;
  localparam int unsigned WAIT_W  = 8;

  // Issue-slot state: which access (if any) was placed on the RAM port this cycle.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StVid   = 2'd1,
    StCpuRd = 2'd2,
    StCpuWr = 2'd3
  } slot_e;

  // Owner of a read travelling through the RAM latency pipeline.
  typedef enum logic [1:0] {
    TagNone = 2'd0,
    TagVid  = 2'd1,
    TagCpu  = 2'd2
  } tag_e;

endpackage

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetches have absolute priority, CPU accesses
// fill idle slots; reads return through a two-stage tag pipeline.
module vram_arbiter
  import zed64_vram_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic               pixel_clock,
  input  logic               reset_n,
  input  logic               vid_req,
  input  logic [VRAM_AW-1:0] vid_adr,
  output logic [VRAM_DW-1:0] vid_dat,
  output logic               vid_valid,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [VRAM_AW-1:0] cpu_adr,
  input  logic [VRAM_DW-1:0] cpu_wdat,
  output logic [VRAM_DW-1:0] cpu_rdat,
  output logic               cpu_ack,
  output logic [VRAM_AW-1:0] ram_adr,
  output logic               ram_we,
  output logic [VRAM_DW-1:0] ram_wdat,
  input  logic [VRAM_DW-1:0] ram_rdat,
  output logic               cpu_starved
);

  localparam logic [WAIT_W-1:0] MaxWait = WAIT_W'(MAX_WAIT);

  slot_e              slot_q, slot_d;
  tag_e               tag0_q, tag0_d, tag1_q;
  logic [VRAM_AW-1:0] ram_adr_q, ram_adr_d;
  logic               ram_we_q, ram_we_d;
  logic [VRAM_DW-1:0] ram_wdat_q, ram_wdat_d;
  logic [VRAM_DW-1:0] vid_dat_q, vid_dat_d;
  logic               vid_valid_q, vid_valid_d;
  logic [VRAM_DW-1:0] cpu_rdat_q, cpu_rdat_d;
  logic               cpu_ack_q, cpu_ack_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               starved_q, starved_d;
  logic               cpu_busy, cpu_grant;

  // A CPU transaction stays in flight up to and including the cycle its ack is
  // visible, so a request still held during the ack is not granted twice.
  assign cpu_busy  = (slot_q == StCpuRd) || (slot_q == StCpuWr) ||
                     (tag1_q == TagCpu) || cpu_ack_q;
  assign cpu_grant = cpu_req && !vid_req && !cpu_busy;

  always_comb begin
    slot_d     = StIdle;
    tag0_d     = TagNone;
    ram_adr_d  = ram_adr_q;
    ram_we_d   = 1'b0;
    ram_wdat_d = ram_wdat_q;
    if (vid_req) begin
      slot_d    = StVid;
      tag0_d    = TagVid;
      ram_adr_d = vid_adr;
    end else if (cpu_grant) begin
      slot_d    = cpu_we ? StCpuWr : StCpuRd;
      tag0_d    = cpu_we ? TagNone : TagCpu;
      ram_adr_d = cpu_adr;
      if (cpu_we) begin
        ram_we_d   = 1'b1;
        ram_wdat_d = cpu_wdat;
      end
    end
  end

  always_comb begin
    vid_valid_d = (tag1_q == TagVid);
    vid_dat_d   = (tag1_q == TagVid) ? ram_rdat : vid_dat_q;
    cpu_rdat_d  = (tag1_q == TagCpu) ? ram_rdat : cpu_rdat_q;
    cpu_ack_d   = (slot_q == StCpuWr) || (tag1_q == TagCpu);
  end

  // Only cycles where the CPU is genuinely pending (not being served) count as waiting.
  always_comb begin
    wait_d = wait_q;
    if (cpu_grant) begin
      wait_d = '0;
    end else if (cpu_req && !cpu_busy && (wait_q != {WAIT_W{1'b1}})) begin
      wait_d = wait_q + WAIT_W'(1);
    end
    starved_d = starved_q || (wait_d == MaxWait);
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_q      <= StIdle;
      tag0_q      <= TagNone;
      tag1_q      <= TagNone;
      ram_adr_q   <= '0;
      ram_we_q    <= 1'b0;
      ram_wdat_q  <= '0;
      vid_dat_q   <= '0;
      vid_valid_q <= 1'b0;
      cpu_rdat_q  <= '0;
      cpu_ack_q   <= 1'b0;
      wait_q      <= '0;
      starved_q   <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      tag0_q      <= tag0_d;
      tag1_q      <= tag0_q;
      ram_adr_q   <= ram_adr_d;
      ram_we_q    <= ram_we_d;
      ram_wdat_q  <= ram_wdat_d;
      vid_dat_q   <= vid_dat_d;
      vid_valid_q <= vid_valid_d;
      cpu_rdat_q  <= cpu_rdat_d;
      cpu_ack_q   <= cpu_ack_d;
      wait_q      <= wait_d;
      starved_q   <= starved_d;
    end
  end

  assign ram_adr     = ram_adr_q;
  assign ram_we      = ram_we_q;
  assign ram_wdat    = ram_wdat_q;
  assign vid_dat     = vid_dat_q;
  assign vid_valid   = vid_valid_q;
  assign cpu_rdat    = cpu_rdat_q;
  assign cpu_ack     = cpu_ack_q;
  assign cpu_starved = starved_q;

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 64, meaning the CPU wait-cycle count (1..255) at which the starvation flag sets.
REQ-002 SHALL have port pixel_clock  in  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port vid_req  in  1  one-cycle video fetch request (char-cell or glyph-row read).
REQ-005 SHALL have port vid_adr  in  13  video fetch address.
REQ-006 SHALL have port vid_dat  out  8  video read data.
REQ-007 SHALL have port vid_valid  out  1  one-cycle pulse qualifying vid_dat.
REQ-008 SHALL have port cpu_req  in  1  CPU request level, held until cpu_ack.
REQ-009 SHALL have port cpu_we  in  1  CPU write (1) / read (0).
REQ-010 SHALL have port cpu_adr  in  13  CPU address.
REQ-011 SHALL have port cpu_wdat  in  8  CPU write data.
REQ-012 SHALL have port cpu_rdat  out  8  CPU read data, valid with cpu_ack on reads.
REQ-013 SHALL have port cpu_ack  out  1  one-cycle completion pulse.
REQ-014 SHALL have port ram_adr  out  13  registered VRAM address.
REQ-015 SHALL have port ram_we  out  1  registered VRAM write enable.
REQ-016 SHALL have port ram_wdat  out  8  registered VRAM write data.
REQ-017 SHALL have port ram_rdat  in  8  VRAM read data; synchronous RAM, one-cycle read latency.
REQ-018 SHALL have port cpu_starved  out  1  sticky starvation flag.

Function
REQ-019 SHALL issue at most one VRAM access per cycle; grant decided on edge E0, ram_* outputs driven from E0.
REQ-020 SHALL give vid_req absolute priority: a vid_req is never delayed, dropped or reordered.
REQ-021 SHALL grant a pending CPU request only on an edge where vid_req=0 and no CPU transaction is in flight.
REQ-022 SHALL use states IDLE, VID, CPU_RD, CPU_WR for the issue slot: IDLE when nothing is granted; VID on vid_req; CPU_RD/CPU_WR on a CPU grant per cpu_we; all transitions possible every cycle.
REQ-023 SHALL return video read data with fixed latency: vid_req sampled at E0 -> vid_valid=1 and vid_dat=ram_rdat captured at E2.
REQ-024 SHALL acknowledge a CPU read via cpu_ack=1 with cpu_rdat after E2 of its grant edge.
REQ-025 SHALL acknowledge a CPU write via cpu_ack=1 after E1 of its grant edge, with ram_we=1 for exactly the E0-E1 cycle.
REQ-026 SHALL track reads in a 2-stage tag pipeline (none/vid/cpu) so back-to-back video reads complete every cycle.
REQ-027 SHALL NOT re-grant a still-asserted cpu_req on the edge its ack is produced; a new CPU transaction is sampled from the following edge.
REQ-028 SHALL hold ram_we=0 and keep ram_adr at its last value when the slot is IDLE or a read.
REQ-029 SHALL count cycles with cpu_req=1 and no grant in an 8-bit saturating counter, cleared on each grant.
REQ-030 SHALL set cpu_starved when the counter reaches MAX_WAIT; it stays set until reset.
REQ-031 SHALL leave an in-flight video read unaffected when vid_req and cpu_req rise on the same edge; the CPU waits.

Reset
REQ-032 SHALL, while reset_n=0, force vid_valid=0, cpu_ack=0, ram_we=0, ram_adr=0, ram_wdat=0, vid_dat=0, cpu_rdat=0, cpu_starved=0, wait counter=0, tags=none, state=IDLE.
REQ-033 SHALL discard any in-flight transaction asserted at reset, producing no vid_valid or cpu_ack.

Structure
REQ-034 SHALL take VRAM_AW=13, VRAM_DW=8, the slot-state encoding and the tag encoding from shared package zed64_vram_pkg.
REQ-035 SHALL be implemented as a single module with no sub-modules.

Verification
REQ-036 SHALL verify video latency: vid_req pulse adr=0x1005 with RAM[0x1005]=0x41 -> vid_valid pulse 2 cycles later, vid_dat=0x41.
REQ-037 SHALL verify video streaming: vid_req high 8 consecutive cycles, adr 0..7 -> 8 consecutive vid_valid pulses in order, cpu_req held throughout -> no grant until vid_req drops.
REQ-038 SHALL verify CPU write then read: write 0xA5 to 0x0123 -> cpu_ack 1 cycle after grant; read 0x0123 -> cpu_ack 2 cycles after grant, cpu_rdat=0xA5.
REQ-039 SHALL verify collision: vid_req and cpu_req (read) on the same edge -> video granted first, CPU granted next edge, both data correct.
REQ-040 SHALL verify starvation: MAX_WAIT=4, vid_req high 5 cycles with cpu_req held -> cpu_starved=1 after the 4th wait cycle, stays 1 after the grant.
REQ-041 SHALL verify reset mid-read: reset_n low 1 cycle after a CPU read grant -> no cpu_ack, all outputs at reset values.
